sram_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the shared 1Mx16 external SRAM on the SLC-3 board. It sits between the memory interface and the SRAM tristate buffer. Requesters are the CPU path (MAR/MDR through Mem2IO) and a DMA/loader port used for program load and debug readout. It serialises their word accesses, generates the active-low SRAM strobes with a fixed access window, and returns read data with a one-cycle acknowledge.

---
 rtl/sram_arbiter.sv | 154 +++++++++++++++
 tb/tb_sram_arbiter.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port (CPU / DMA) arbiter and access sequencer
// for the shared 1Mx16 SRAM; fixed strobe window, one-cycle ack.
//
// Ports:
//   Clk, Reset          clock, async active-high reset
//   cpu_* / dma_*       req/we/addr/wdata in, ack/rdata out per port
//   Mem_CE..Mem_WE      active-low SRAM strobes (Moore, from state)
//   ADDR, Data_to_SRAM  latched address (zero-extended) and write data
//   data_oe             tristate enable, high in a write access window
//   Data_from_SRAM      read data from the tristate buffer
//   busy, owner         not-IDLE flag; current/last granted port
module sram_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int ADDR_W        = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic [15:0]       cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [15:0]       dma_wdata,
    output logic              dma_ack,
    output logic [15:0]       dma_rdata,
    output logic              Mem_CE,
    output logic              Mem_UB,
    output logic              Mem_LB,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic [19:0]       ADDR,
    output logic [15:0]       Data_to_SRAM,
    output logic              data_oe,
    input  logic [15:0]       Data_from_SRAM,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [3:0] LOAD = 4'(ACCESS_CYCLES - 1);
    localparam logic       CPU  = 1'b0;
    localparam logic       DMA  = 1'b1;

    state_t            state;
    state_t            state_nx;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nx;
    logic              last_served;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic              any_req;
    logic              winner;
    logic              grant;
    logic              last_edge;
    logic              in_access;

    // A tie goes to the port not served last; otherwise
    // whichever single port is requesting.
    always_comb begin
        any_req = cpu_req | dma_req;
        winner  = dma_req;
        if (cpu_req && dma_req)
            winner = ~last_served;
    end

    assign grant     = (state == IDLE) && any_req;
    assign last_edge = (state == ACCESS) && (cnt == 4'd0);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_nx = ACCESS;
                    cnt_nx   = LOAD;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0)
                    state_nx = DONE;
                else
                    cnt_nx = cnt - 4'd1;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request inputs are only looked at in the grant cycle;
    // everything after that runs from these latched copies.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            owner       <= CPU;
            last_served <= DMA;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else if (grant) begin
            owner       <= winner;
            last_served <= winner;
            we_q        <= winner ? dma_we    : cpu_we;
            addr_q      <= winner ? dma_addr  : cpu_addr;
            wdata_q     <= winner ? dma_wdata : cpu_wdata;
        end
    end

    // Read data captured on the final ACCESS edge, OE still low.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else if (last_edge && !we_q) begin
            if (owner == DMA)
                dma_rdata <= Data_from_SRAM;
            else
                cpu_rdata <= Data_from_SRAM;
        end
    end

    assign in_access    = (state == ACCESS);
    assign Mem_CE       = ~in_access;
    assign Mem_UB       = ~in_access;
    assign Mem_LB       = ~in_access;
    assign Mem_OE       = ~(in_access & ~we_q);
    assign Mem_WE       = ~(in_access & we_q);
    assign data_oe      = in_access & we_q;
    assign ADDR         = 20'(addr_q);
    assign Data_to_SRAM = wdata_q;
    assign busy         = (state != IDLE);
    assign cpu_ack      = (state == DONE) && (owner == CPU);
    assign dma_ack      = (state == DONE) && (owner == DMA);

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: scoreboard bench for sram_arbiter with an SRAM
// model; extra instances cover 1- and 15-cycle access windows.
module tb_sram_arbiter;

    logic        Clk;
    logic        Reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_ack, dma_ack;
    logic [15:0] cpu_rdata, dma_rdata;
    logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
    logic [19:0] ADDR;
    logic [15:0] Data_to_SRAM, Data_from_SRAM;
    logic        data_oe, busy, owner;

    logic        a1_cack, a1_dack, a1_ce, a1_ub, a1_lb, a1_oe, a1_we;
    logic        a1_doe, a1_busy, a1_owner;
    logic [15:0] a1_crd, a1_drd, a1_dout;
    logic [19:0] a1_addr;
    logic        a15_cack, a15_dack, a15_ce, a15_ub, a15_lb;
    logic        a15_oe, a15_we, a15_doe, a15_busy, a15_owner;
    logic [15:0] a15_crd, a15_drd, a15_dout;
    logic [19:0] a15_addr;

    typedef struct {
        logic        port;
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mem [0:1023];
    int          n_checks = 0;
    int          n_fail   = 0;

    sram_arbiter #(.ACCESS_CYCLES(2), .ADDR_W(16)) dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
        .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .ADDR(ADDR),
        .Data_to_SRAM(Data_to_SRAM), .data_oe(data_oe),
        .Data_from_SRAM(Data_from_SRAM), .busy(busy), .owner(owner)
    );

    sram_arbiter #(.ACCESS_CYCLES(1), .ADDR_W(16)) dut1 (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(a1_cack), .cpu_rdata(a1_crd),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_ack(a1_dack), .dma_rdata(a1_drd),
        .Mem_CE(a1_ce), .Mem_UB(a1_ub), .Mem_LB(a1_lb),
        .Mem_OE(a1_oe), .Mem_WE(a1_we), .ADDR(a1_addr),
        .Data_to_SRAM(a1_dout), .data_oe(a1_doe),
        .Data_from_SRAM(Data_from_SRAM), .busy(a1_busy),
        .owner(a1_owner)
    );

    sram_arbiter #(.ACCESS_CYCLES(15), .ADDR_W(16)) dut15 (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(a15_cack), .cpu_rdata(a15_crd),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_ack(a15_dack), .dma_rdata(a15_drd),
        .Mem_CE(a15_ce), .Mem_UB(a15_ub), .Mem_LB(a15_lb),
        .Mem_OE(a15_oe), .Mem_WE(a15_we), .ADDR(a15_addr),
        .Data_to_SRAM(a15_dout), .data_oe(a15_doe),
        .Data_from_SRAM(Data_from_SRAM), .busy(a15_busy),
        .owner(a15_owner)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // SRAM model: reads only while OE is low, otherwise junk.
    assign Data_from_SRAM = !Mem_OE ? mem[ADDR[9:0]] : 16'hDEAD;

    always @(posedge Clk)
        if (!Mem_CE && !Mem_WE)
            mem[ADDR[9:0]] <= Data_to_SRAM;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
        mem[10'h012] <= 16'hBEEF;
        mem[10'h055] <= 16'hA5A5;
    end

    task automatic do_reset();
        Reset   = 1'b1;
        cpu_req = 1'b0;
        dma_req = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        @(negedge Clk);
        n_checks++;
        if ({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, data_oe}
            !== 6'b111110) begin
            n_fail++;
            $display("FAIL reset_strobes got %b want 111110",
                {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, data_oe});
        end
        n_checks++;
        if ({cpu_ack, dma_ack, busy, owner} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 0000",
                {cpu_ack, dma_ack, busy, owner});
        end
        n_checks++;
        if ({cpu_rdata, dma_rdata, Data_to_SRAM, ADDR} !== 68'h0) begin
            n_fail++;
            $display("FAIL reset_data got %h %h %h %h want 0",
                cpu_rdata, dma_rdata, Data_to_SRAM, ADDR);
        end
        Reset = 1'b0;
        @(negedge Clk);
        n_checks++;
        if ({busy, a1_busy, a15_busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_idle got %b want 000",
                {busy, a1_busy, a15_busy});
        end
    endtask

    task automatic test_cpu_read();
        int win = 0;
        int lat = 0;
        exp_t e;
        exp_q.push_back('{1'b0, 1'b0, 16'h0012, 16'hBEEF});
        cpu_we = 1'b0; cpu_addr = 16'h0012; cpu_req = 1'b1;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge Clk);
            if (!Mem_CE) begin
                win++;
                n_checks++;
                if ({Mem_OE, Mem_WE, data_oe, ADDR}
                    !== {3'b010, 20'h00012}) begin
                    n_fail++;
                    $display("FAIL rd_window got %b %h want 010 00012",
                        {Mem_OE, Mem_WE, data_oe}, ADDR);
                end
            end
            n_checks++;
            if (dma_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL rd_dma_ack got %b want 0", dma_ack);
            end
            if (cpu_ack === 1'b1 && exp_q.size() > 0) begin
                lat = c;
                cpu_req = 1'b0;
                e = exp_q.pop_front();
                n_checks++;
                if (cpu_rdata !== e.data || owner !== e.port) begin
                    n_fail++;
                    $display("FAIL rd_data got %h/%b want %h/%b",
                        cpu_rdata, owner, e.data, e.port);
                end
            end
        end
        cpu_req = 1'b0;
        n_checks++;
        if (win !== 2 || lat !== 3) begin
            n_fail++;
            $display("FAIL rd_timing got win=%0d lat=%0d want 2 3",
                win, lat);
        end
        exp_q.delete();
    endtask

    task automatic test_dma_write();
        int win = 0;
        int acks = 0;
        exp_t e;
        exp_q.push_back('{1'b1, 1'b1, 16'hFFFF, 16'h1234});
        @(negedge Clk);
        dma_we = 1'b1; dma_addr = 16'hFFFF; dma_wdata = 16'h1234;
        dma_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge Clk);
            if (!Mem_CE) begin
                win++;
                n_checks++;
                if ({Mem_OE, Mem_WE, data_oe, ADDR, Data_to_SRAM}
                    !== {3'b101, 20'h0FFFF, 16'h1234}) begin
                    n_fail++;
                    $display("FAIL wr_window got %b %h %h want 101 0ffff 1234",
                        {Mem_OE, Mem_WE, data_oe}, ADDR, Data_to_SRAM);
                end
            end
            n_checks++;
            if (cpu_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL wr_cpu_ack got %b want 0", cpu_ack);
            end
            if (dma_ack === 1'b1) begin
                acks++;
                dma_req = 1'b0;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    n_checks++;
                    if (mem[e.addr[9:0]] !== e.data || owner !== e.port) begin
                        n_fail++;
                        $display("FAIL wr_mem got %h/%b want %h/%b",
                            mem[e.addr[9:0]], owner, e.data, e.port);
                    end
                end
            end
        end
        n_checks++;
        if (win !== 2 || acks !== 1 || dma_rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL wr_summary got win=%0d acks=%0d rd=%h want 2 1 0000",
                win, acks, dma_rdata);
        end
        exp_q.delete();
    endtask

    task automatic test_round_robin();
        int cpu_done = 0;
        int dma_done = 0;
        logic ap;
        logic [15:0] rd;
        exp_t e;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back('{1'b0, 1'b0, 16'h0012, 16'hBEEF});
            exp_q.push_back('{1'b1, 1'b0, 16'hFFFF, 16'h1234});
        end
        cpu_we = 1'b0; cpu_addr = 16'h0012;
        dma_we = 1'b0; dma_addr = 16'hFFFF;
        cpu_req = 1'b1; dma_req = 1'b1;
        for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
            @(negedge Clk);
            if (!Mem_CE) begin
                n_checks++;
                if (owner !== exp_q[0].port) begin
                    n_fail++;
                    $display("FAIL rr_owner got %b want %b",
                        owner, exp_q[0].port);
                end
            end
            if (cpu_ack === 1'b1 || dma_ack === 1'b1) begin
                ap = dma_ack;
                rd = dma_ack ? dma_rdata : cpu_rdata;
                e = exp_q.pop_front();
                n_checks++;
                if ((cpu_ack & dma_ack) || ap !== e.port
                    || rd !== e.data) begin
                    n_fail++;
                    $display("FAIL rr_grant got acks=%b%b rd=%h want port %b rd %h",
                        cpu_ack, dma_ack, rd, e.port, e.data);
                end
            end
            if (cpu_ack === 1'b1) begin
                cpu_req = 1'b0; cpu_done++;
            end else if (!cpu_req && cpu_done < 2) cpu_req = 1'b1;
            if (dma_ack === 1'b1) begin
                dma_req = 1'b0; dma_done++;
            end else if (!dma_req && dma_done < 2) dma_req = 1'b1;
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            n_checks++;
            if ({cpu_ack, dma_ack} !== 2'b00) begin
                n_fail++;
                $display("FAIL rr_extra_ack got %b%b want 00",
                    cpu_ack, dma_ack);
            end
        end
        n_checks++;
        if (cpu_done !== 2 || dma_done !== 2 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rr_count got %0d %0d left=%0d want 2 2 0",
                cpu_done, dma_done, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_drop_mid();
        int lat = 0;
        exp_t e;
        exp_q.push_back('{1'b0, 1'b0, 16'h0055, 16'hA5A5});
        cpu_we = 1'b0; cpu_addr = 16'h0055; cpu_req = 1'b1;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge Clk);
            if (!Mem_CE) begin
                n_checks++;
                if (ADDR !== 20'h00055) begin
                    n_fail++;
                    $display("FAIL drop_addr got %h want 00055", ADDR);
                end
            end
            if (c == 1) begin
                cpu_req = 1'b0;
                cpu_addr = 16'h0777;
            end
            if (cpu_ack === 1'b1 && exp_q.size() > 0) begin
                lat = c;
                e = exp_q.pop_front();
                n_checks++;
                if (cpu_rdata !== e.data) begin
                    n_fail++;
                    $display("FAIL drop_data got %h want %h",
                        cpu_rdata, e.data);
                end
            end
        end
        n_checks++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL drop_ack got lat=%0d want 3", lat);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            n_checks++;
            if ({busy, Mem_CE, ADDR} !== {2'b01, 20'h00055}) begin
                n_fail++;
                $display("FAIL drop_idle got busy=%b ce=%b addr=%h want 0 1 00055",
                    busy, Mem_CE, ADDR);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        @(negedge Clk);
        cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 16'h5555;
        cpu_req = 1'b1;
        @(negedge Clk);
        n_checks++;
        if ({Mem_CE, Mem_WE} !== 2'b00) begin
            n_fail++;
            $display("FAIL rstmid_pre got %b want 00", {Mem_CE, Mem_WE});
        end
        #1 Reset = 1'b1;
        #1;
        n_checks++;
        if ({Mem_CE, Mem_WE, data_oe, busy} !== 4'b1100) begin
            n_fail++;
            $display("FAIL rstmid_async got %b want 1100",
                {Mem_CE, Mem_WE, data_oe, busy});
        end
        cpu_req = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge Clk);
            if (cpu_ack === 1'b1 || dma_ack === 1'b1) acks++;
        end
        n_checks++;
        if (acks !== 0 || busy !== 1'b0 || mem[10'h040] !== 16'h0000) begin
            n_fail++;
            $display("FAIL rstmid_after got acks=%0d busy=%b mem=%h want 0 0 0000",
                acks, busy, mem[10'h040]);
        end
    endtask

    task automatic test_access_lengths();
        int w1 = 0, w2 = 0, w15 = 0;
        int l1 = 0, l2 = 0, l15 = 0;
        exp_t e;
        do_reset();
        exp_q.push_back('{1'b0, 1'b1, 16'h0100, 16'h0F0F});
        cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 16'h0F0F;
        cpu_req = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge Clk);
            if (c == 1) cpu_req = 1'b0;
            if (!a1_ce) w1++;
            if (!Mem_CE) w2++;
            if (!a15_ce) w15++;
            if (a1_cack === 1'b1 && l1 == 0) l1 = c;
            if (a15_cack === 1'b1 && l15 == 0) l15 = c;
            if (cpu_ack === 1'b1 && l2 == 0) begin
                l2 = c;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    n_checks++;
                    if (mem[e.addr[9:0]] !== e.data) begin
                        n_fail++;
                        $display("FAIL len_mem got %h want %h",
                            mem[e.addr[9:0]], e.data);
                    end
                end
            end
        end
        n_checks++;
        if (w1 !== 1 || l1 !== 2) begin
            n_fail++;
            $display("FAIL len_ac1 got win=%0d lat=%0d want 1 2", w1, l1);
        end
        n_checks++;
        if (w2 !== 2 || l2 !== 3) begin
            n_fail++;
            $display("FAIL len_ac2 got win=%0d lat=%0d want 2 3", w2, l2);
        end
        n_checks++;
        if (w15 !== 15 || l15 !== 16) begin
            n_fail++;
            $display("FAIL len_ac15 got win=%0d lat=%0d want 15 16",
                w15, l15);
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_round_robin();
        test_drop_mid();
        test_reset_mid();
        test_access_lengths();
        $display("End of test - %0d assertions evaluated, %0d failures",
            n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
